// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: N-channel valid/ready merge with a single registered output
// stage. The grant is round-robin (rotating pointer) or fixed priority
// (channel 0 highest), chosen by FIXED_PRIO. The output stage refills in the
// same cycle it drains, so it sustains one word per cycle.
module rr_mux_arbiter #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [$clog2(N_CH)-1:0] out_ch,
  input  logic                    out_ready
);

  localparam int unsigned CW = $clog2(N_CH);
  // One extra bit so ptr + offset never overflows before the wrap correction.
  localparam int unsigned SW = CW + 1;

  logic [CW-1:0]    ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_ch_q, out_ch_d;

  logic             load_en;
  logic             any_grant;
  logic [CW-1:0]    gnt_idx;
  logic [N_CH-1:0]  grant;
  logic [SW-1:0]    cand;
  logic [WIDTH-1:0] sel_data;

  // The stage accepts a new word when empty or when its word leaves this cycle.
  always_comb begin
    load_en = !out_valid_q || out_ready;
  end

  // Grant search: walk channels starting at ptr (or at 0 for fixed priority)
  // and pick the first one with in_valid set. Depends only on in_valid and ptr.
  always_comb begin
    any_grant = 1'b0;
    gnt_idx   = '0;
    grant     = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (FIXED_PRIO != 0) begin
        cand = SW'(k);
      end else begin
        cand = {1'b0, ptr_q} + SW'(k);
        if (cand >= SW'(N_CH)) begin
          cand = cand - SW'(N_CH);
        end
      end
      if (!any_grant && in_valid[cand[CW-1:0]]) begin
        any_grant = 1'b1;
        gnt_idx   = cand[CW-1:0];
      end
    end
    if (any_grant) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  // Ready is the grant qualified by stage availability, forced low in reset.
  always_comb begin
    if (rst) begin
      in_ready = '0;
    end else begin
      in_ready = grant & {N_CH{load_en}};
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    sel_data = in_data[gnt_idx*WIDTH +: WIDTH];
  end

  // Next-state: load on grant, empty when nothing to load, hold when stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (any_grant) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_ch_d    = gnt_idx;
        if (FIXED_PRIO == 0) begin
          if (gnt_idx == CW'(N_CH - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = gnt_idx + CW'(1);
          end
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; reset discards any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  // Output drive.
  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_ch    = out_ch_q;
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Testbench for rr_mux_arbiter: one round-robin and one fixed-priority
// instance share the same stimulus. Directed table, a fixed-priority
// sequence and a random soak, all checked against a behavioural model
// that keeps an explicit channel priority list per instance.
module tb_rr_mux_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic          out_ready;

  logic [N-1:0]  rdy_rr, rdy_fp;
  logic          ov_rr, ov_fp;
  logic [W-1:0]  od_rr, od_fp;
  logic [1:0]    och_rr, och_fp;

  rr_mux_arbiter #(.N_CH(N), .WIDTH(W), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_ch(och_rr),
    .out_ready(out_ready)
  );

  rr_mux_arbiter #(.N_CH(N), .WIDTH(W), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_fp), .out_valid(ov_fp), .out_data(od_fp), .out_ch(och_fp),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed priority.
  logic       m_ov [2];
  logic [7:0] m_od [2];
  int         m_och[2];
  int         order[2][N];   // channels in current priority order
  int         wait_cnt[N];   // grants to others while a channel stays valid
  logic [7:0] sbq[2*N][$];   // per-instance, per-channel accepted words

  logic [N-1:0] rr_rdy_seen, fp_rdy_seen;

  typedef struct {
    logic         rst;
    logic [3:0]   vld;
    logic [31:0]  data;
    logic         ordy;
    logic [3:0]   e_rdy;
    logic         e_ov;
    logic [7:0]   e_od;
    logic [1:0]   e_och;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input int inst, input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[order[inst][i]]) return order[inst][i];
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int inst = 0; inst < 2; inst++) begin
      m_ov[inst]  = 1'b0;
      m_od[inst]  = '0;
      m_och[inst] = 0;
      for (int i = 0; i < N; i++) order[inst][i] = i;
    end
    for (int c = 0; c < N; c++) wait_cnt[c] = 0;
    for (int q = 0; q < 2*N; q++) sbq[q].delete();
  endtask

  // One clock cycle: drive, check ready and scoreboard before the edge,
  // advance the model at the edge, check registered outputs after it.
  task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d, input logic o);
    int         w[2];
    logic       le[2];
    logic [3:0] er[2];
    logic [7:0] front;
    rst = r; in_valid = v; in_data = d; out_ready = o;
    #2;
    for (int inst = 0; inst < 2; inst++) begin
      le[inst] = !m_ov[inst] || o;
      w[inst]  = winner(inst, v);
      er[inst] = (!r && le[inst] && w[inst] >= 0) ? (4'b0001 << w[inst]) : 4'b0000;
    end
    chk("in_ready_rr", 32'(rdy_rr), 32'(er[0]));
    chk("in_ready_fp", 32'(rdy_fp), 32'(er[1]));
    rr_rdy_seen = rdy_rr;
    fp_rdy_seen = rdy_fp;
    if (!r) begin
      // Drain side first: the word leaving belongs to the previous transfer.
      if (ov_rr && o) begin
        if (sbq[och_rr].size() == 0) chk("sb_rr_lost", 32'(sbq[och_rr].size()), 32'd1);
        else begin front = sbq[och_rr].pop_front(); chk("sb_rr_data", 32'(od_rr), 32'(front)); end
      end
      if (ov_fp && o) begin
        if (sbq[N + och_fp].size() == 0) chk("sb_fp_lost", 32'(sbq[N + och_fp].size()), 32'd1);
        else begin front = sbq[N + och_fp].pop_front(); chk("sb_fp_data", 32'(od_fp), 32'(front)); end
      end
      for (int inst = 0; inst < 2; inst++)
        if (er[inst] != 0) sbq[inst*N + w[inst]].push_back(d[w[inst]*W +: W]);
      // Fairness: no valid channel sees N or more grants to others.
      for (int c = 0; c < N; c++) begin
        if (!v[c]) wait_cnt[c] = 0;
        else if (er[0] != 0) begin
          if (c == w[0]) wait_cnt[c] = 0;
          else begin
            wait_cnt[c]++;
            chk($sformatf("rr_fair_ch%0d", c), 32'(wait_cnt[c] < N), 32'd1);
          end
        end
      end
    end
    @(posedge clk);
    if (r) model_reset();
    else begin
      for (int inst = 0; inst < 2; inst++) begin
        if (le[inst]) begin
          if (w[inst] >= 0) begin
            m_ov[inst]  = 1'b1;
            m_od[inst]  = d[w[inst]*W +: W];
            m_och[inst] = w[inst];
            if (inst == 0)
              for (int i = 0; i < N; i++) order[0][i] = (w[0] + 1 + i) % N;
          end else begin
            m_ov[inst] = 1'b0;
          end
        end
      end
    end
    #1;
    chk("out_valid_rr", 32'(ov_rr),  32'(m_ov[0]));
    chk("out_data_rr",  32'(od_rr),  32'(m_od[0]));
    chk("out_ch_rr",    32'(och_rr), 32'(m_och[0]));
    chk("out_valid_fp", 32'(ov_fp),  32'(m_ov[1]));
    chk("out_data_fp",  32'(od_fp),  32'(m_od[1]));
    chk("out_ch_fp",    32'(och_fp), 32'(m_och[1]));
  endtask

  initial begin
    // rst, vld, data, out_ready | in_ready (before edge), out_valid/data/ch (after)
    tbl[0]  = '{1'b0, 4'b0100, 32'h00A5_0000, 1'b0, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tbl[1]  = '{1'b1, 4'b1111, 32'h1312_1110, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
    tbl[2]  = '{1'b0, 4'b1111, 32'h1312_1110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[3]  = '{1'b0, 4'b1111, 32'h1312_1110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[4]  = '{1'b0, 4'b1111, 32'h1312_1110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[5]  = '{1'b0, 4'b1111, 32'h1312_1110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[6]  = '{1'b0, 4'b1111, 32'h1312_1110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[7]  = '{1'b0, 4'b1111, 32'h1312_1110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[8]  = '{1'b0, 4'b1111, 32'h1312_1110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tbl[9]  = '{1'b0, 4'b1111, 32'h1312_1110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tbl[10] = '{1'b0, 4'b0010, 32'h0000_3C00, 1'b1, 4'b0010, 1'b1, 8'h3C, 2'd1};
    tbl[11] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
    tbl[12] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
    tbl[13] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
    tbl[14] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
    tbl[15] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
    tbl[16] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h3C, 2'd1};
    tbl[17] = '{1'b0, 4'b0100, 32'h0022_0000, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
    tbl[18] = '{1'b0, 4'b0011, 32'h0000_4140, 1'b1, 4'b0001, 1'b1, 8'h40, 2'd0};
    tbl[19] = '{1'b0, 4'b0011, 32'h0000_4140, 1'b1, 4'b0010, 1'b1, 8'h41, 2'd1};
    tbl[20] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h41, 2'd1};

    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b1, 4'b0000, 32'h0, 1'b0);
    step(1'b1, 4'b0000, 32'h0, 1'b0);

    // Directed table on the round-robin instance.
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].data, tbl[i].ordy);
      chk($sformatf("tbl%0d_in_ready", i),  32'(rr_rdy_seen), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_out_valid", i), 32'(ov_rr),       32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_data", i),  32'(od_rr),       32'(tbl[i].e_od));
      chk($sformatf("tbl%0d_out_ch", i),    32'(och_rr),      32'(tbl[i].e_och));
    end

    // Fixed priority: ch0 and ch3 both valid, ch0 always wins.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b1001, 32'h3300_0030, 1'b1);
      chk($sformatf("fp%0d_in_ready", i),  32'(fp_rdy_seen),    32'h1);
      chk($sformatf("fp%0d_ready_ch3", i), 32'(fp_rdy_seen[3]), 32'h0);
      chk($sformatf("fp%0d_out_ch", i),    32'(och_fp),         32'h0);
      chk($sformatf("fp%0d_out_data", i),  32'(od_fp),          32'h30);
    end

    // Random soak with occasional reset.
    for (int i = 0; i < 10000; i++) begin
      logic [3:0]  v;
      logic [31:0] d;
      for (int c = 0; c < N; c++) v[c] = ($urandom_range(0, 3) != 0);
      d = $urandom;
      step(($urandom_range(0, 999) == 0), v, d, ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
